hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the decode stage.
- Detects load-use hazards between decode and execute, flushes on taken branches/jumps resolved in EX, and sequences halt: drain the pipe, then stop.
- Drives the decoder `bubble` input and the PC/IF-ID write enables.
- Sits beside the instruction decoder; consumes its register fields and control outputs.

---
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing controller: load-use stalls, branch flushes, halt drain/stop.
// Define HAZARD_PERF_EN to add the stall_count/flush_count performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_read_reg1,
    input  logic [REG_ADDR_W-1:0] id_read_reg2,
    input  logic [2:0]            id_itype,
    input  logic                  id_jal,
    input  logic                  id_jalr,
    input  logic                  id_hlt,
    input  logic                  ex_mem_reg,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  bubble,
    output logic                  flush_ifid,
    output logic                  halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    localparam int MAX_CYC = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 4) ? $clog2(MAX_CYC) : 2;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               uses_rs1, uses_rs2, lu;

    always_comb begin
        uses_rs1 = ~id_jal;
        uses_rs2 = (id_itype == 3'b011) | (id_itype == 3'b010) |
                   ((id_itype == 3'b110) & ~id_jal & ~id_jalr);
        lu = id_valid & ex_mem_reg & ex_reg_write & (ex_write_reg != '0) &
             ((uses_rs1 & (id_read_reg1 == ex_write_reg)) |
              (uses_rs2 & (id_read_reg2 == ex_write_reg)));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        halted     = 1'b0;

        if (state_q == HALTED) begin
            halted     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
        end else if (ex_branch_taken) begin
            // A taken branch wins in every live state; in DRAIN it cancels the pending halt.
            flush_ifid = 1'b1;
            bubble     = 1'b1;
            state_d    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d      = FLUSH_LOAD;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (lu) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        bubble     = 1'b1;
                    end else if (id_valid && id_hlt) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        state_d    = DRAIN;
                        cnt_d      = DRAIN_LOAD;
                    end
                end
                FLUSH: begin
                    bubble     = 1'b1;
                    flush_ifid = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = RUN;
                end
                DRAIN: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    bubble     = 1'b1;
                    if (cnt_q == '0) state_d = HALTED;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = RUN;
            endcase
        end

        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            flush_ifid = 1'b0;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic        lu_stall;

    // Neither term can be set in HALTED, so both counters freeze there.
    always_comb begin
        lu_stall      = (state_q == RUN) & ~ex_branch_taken & lu;
        stall_count_d = stall_count_q + {31'd0, lu_stall};
        flush_count_d = flush_count_q + {31'd0, flush_ifid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: FLUSH_CYCLES=1 and FLUSH_CYCLES=2 instances on shared stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_read_reg1, id_read_reg2;
    logic [2:0] id_itype;
    logic       id_jal, id_jalr, id_hlt;
    logic       ex_mem_reg, ex_reg_write;
    logic [4:0] ex_write_reg;
    logic       ex_branch_taken;

    logic pc_a, ifid_a, bub_a, fl_a, hlt_a;
    logic pc_b, ifid_b, bub_b, fl_b, hlt_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_a, flcnt_a, stall_b, flcnt_b;
`endif

    hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_itype(id_itype),
        .id_jal(id_jal), .id_jalr(id_jalr), .id_hlt(id_hlt),
        .ex_mem_reg(ex_mem_reg), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_a), .ifid_write(ifid_a), .bubble(bub_a), .flush_ifid(fl_a), .halted(hlt_a)
`ifdef HAZARD_PERF_EN
        , .stall_count(stall_a), .flush_count(flcnt_a)
`endif
    );

    hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .DRAIN_CYCLES(3)) dut_f2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_itype(id_itype),
        .id_jal(id_jal), .id_jalr(id_jalr), .id_hlt(id_hlt),
        .ex_mem_reg(ex_mem_reg), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_b), .ifid_write(ifid_b), .bubble(bub_b), .flush_ifid(fl_b), .halted(hlt_b)
`ifdef HAZARD_PERF_EN
        , .stall_count(stall_b), .flush_count(flcnt_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, expressed as remaining-cycle budgets per instance.
    // Output vector bit order: {pc_write, ifid_write, bubble, flush_ifid, halted}.
    bit          m_halt [2];
    int          m_flush[2];
    int          m_drain[2];
    int unsigned m_stall[2];
    int unsigned m_fcnt [2];
    logic [4:0]  sb0[$];
    logic [4:0]  sb1[$];

    function automatic bit model_lu();
        bit u1, u2;
        u1 = !id_jal;
        u2 = (id_itype == 3'b011) || (id_itype == 3'b010) ||
             (id_itype == 3'b110 && !id_jal && !id_jalr);
        return id_valid && ex_mem_reg && ex_reg_write && (ex_write_reg != 5'd0) &&
               ((u1 && id_read_reg1 == ex_write_reg) || (u2 && id_read_reg2 == ex_write_reg));
    endfunction

    task automatic model_step(input int k, output logic [4:0] e);
        int fc;
        fc = (k == 0) ? 1 : 2;
        if (!rst_n) begin
            m_halt[k] = 0; m_flush[k] = 0; m_drain[k] = 0;
            m_stall[k] = 0; m_fcnt[k] = 0;
            e = 5'b00100;
            return;
        end
        if (m_halt[k]) begin
            e = 5'b00101;
        end else if (ex_branch_taken) begin
            e = 5'b11110;
            m_flush[k] = fc - 1;
            m_drain[k] = 0;
        end else if (m_flush[k] > 0) begin
            e = 5'b11110;
            m_flush[k]--;
        end else if (m_drain[k] > 0) begin
            e = 5'b00100;
            m_drain[k]--;
            if (m_drain[k] == 0) m_halt[k] = 1;
        end else if (model_lu()) begin
            e = 5'b00100;
            m_stall[k]++;
        end else if (id_valid && id_hlt) begin
            e = 5'b00000;
            m_drain[k] = 3;
        end else begin
            e = 5'b11000;
        end
        if (e[1]) m_fcnt[k]++;
    endtask

    // Called just after a posedge: push expectations, check on the negedge, advance past next posedge.
    task automatic tick(input string tag);
        logic [4:0] e;
        model_step(0, e); sb0.push_back(e);
        model_step(1, e); sb1.push_back(e);
        @(negedge clk);
        check_eq({tag, "/f1"}, {27'd0, pc_a, ifid_a, bub_a, fl_a, hlt_a}, {27'd0, sb0.pop_front()});
        check_eq({tag, "/f2"}, {27'd0, pc_b, ifid_b, bub_b, fl_b, hlt_b}, {27'd0, sb1.pop_front()});
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_EN
        check_eq({tag, "_stall_f1"}, stall_a, m_stall[0]);
        check_eq({tag, "_flush_f1"}, flcnt_a, m_fcnt[0]);
        check_eq({tag, "_stall_f2"}, stall_b, m_stall[1]);
        check_eq({tag, "_flush_f2"}, flcnt_b, m_fcnt[1]);
`endif
    endtask

    task automatic idle_in();
        id_valid = 1'b1; id_read_reg1 = 5'd1; id_read_reg2 = 5'd2; id_itype = 3'b011;
        id_jal = 1'b0; id_jalr = 1'b0; id_hlt = 1'b0;
        ex_mem_reg = 1'b0; ex_reg_write = 1'b0; ex_write_reg = 5'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic load_in(input logic [4:0] r);
        ex_mem_reg = 1'b1; ex_reg_write = 1'b1; ex_write_reg = r;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        #1;
        tick("reset0");
        tick("reset1");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick("run");

        // Load-use variants
        load_in(5'd5); id_read_reg2 = 5'd5;                 tick("lu_rtype_rs2");
        idle_in();                                           tick("lu_cleared");
        load_in(5'd0); id_read_reg1 = 5'd0; id_read_reg2 = 5'd0; tick("lu_x0");
        idle_in(); load_in(5'd5); id_itype = 3'b110; id_jal = 1'b1;
        id_read_reg1 = 5'd5; id_read_reg2 = 5'd5;            tick("lu_jal");
        idle_in(); load_in(5'd5); id_itype = 3'b001; id_read_reg2 = 5'd5; tick("lu_itype_norrs2");
        idle_in(); load_in(5'd5); id_itype = 3'b010; id_read_reg2 = 5'd5; tick("lu_store_rs2");
        idle_in(); load_in(5'd5); id_itype = 3'b110; id_read_reg2 = 5'd5; tick("lu_branch_rs2");
        idle_in(); load_in(5'd5); id_itype = 3'b110; id_jalr = 1'b1; id_read_reg2 = 5'd5; tick("lu_jalr_rs2");
        idle_in(); load_in(5'd5); id_itype = 3'b110; id_jalr = 1'b1; id_read_reg1 = 5'd5; tick("lu_jalr_rs1");
        idle_in(); load_in(5'd5); id_read_reg1 = 5'd5; ex_reg_write = 1'b0; tick("lu_nowrite");
        idle_in(); load_in(5'd5); id_read_reg1 = 5'd5; ex_mem_reg = 1'b0; tick("lu_notload");
        idle_in(); load_in(5'd5); id_read_reg1 = 5'd5; id_valid = 1'b0; tick("lu_invalid");
        idle_in();                                           tick("run");

        // Counter segment from a clean reset: 3 stalls and one branch
        rst_n = 1'b0; tick("perf_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_in(); load_in(5'd7); id_read_reg1 = 5'd7; tick("perf_lu");
            idle_in();                                     tick("perf_run");
        end
        ex_branch_taken = 1'b1; tick("perf_br");
        idle_in();              tick("perf_after");
        tick("perf_after2");
        check_perf("perf");

        // Branch taken while a load-use is also present
        idle_in(); load_in(5'd5); id_read_reg2 = 5'd5; ex_branch_taken = 1'b1; tick("br_lu0");
        ex_branch_taken = 1'b0;                                                 tick("br_lu1");
        idle_in();                                                              tick("br_lu_run");
        tick("br_lu_run2");

        // Halt: stop cycle, drain (hazards ignored), then sticky halt
        id_hlt = 1'b1;                                       tick("hlt_issue");
        load_in(5'd1);                                       tick("drain1");
        tick("drain2");
        idle_in();                                           tick("drain3");
        for (int i = 0; i < 12; i++) begin
            id_hlt = 1'($urandom_range(0, 1));
            ex_branch_taken = 1'($urandom_range(0, 1));
            load_in(5'd1);
            tick("halted");
        end

        // Reset while halted: outputs drop to reset values at once
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_f1", {27'd0, pc_a, ifid_a, bub_a, fl_a, hlt_a}, 32'b00100);
        check_eq("rst_async_f2", {27'd0, pc_b, ifid_b, bub_b, fl_b, hlt_b}, 32'b00100);
        idle_in();                                           tick("rst_halted");
        rst_n = 1'b1;                                        tick("run_after_rst");
        check_perf("perf_rst");

        // Halt cancelled by an older branch resolving on the 2nd drain cycle
        id_hlt = 1'b1;                                       tick("hlt2_issue");
        id_hlt = 1'b0;                                       tick("hlt2_drain1");
        ex_branch_taken = 1'b1;                              tick("hlt2_br");
        ex_branch_taken = 1'b0;                              tick("hlt2_post1");
        for (int i = 0; i < 6; i++) tick("hlt2_run");

        // Randomised traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            rst_n           = ($urandom_range(0, 39) != 0);
            id_valid        = ($urandom_range(0, 7) != 0);
            id_read_reg1    = 5'($urandom_range(0, 3));
            id_read_reg2    = 5'($urandom_range(0, 3));
            id_itype        = 3'($urandom_range(0, 7));
            id_jal          = ($urandom_range(0, 5) == 0);
            id_jalr         = ($urandom_range(0, 5) == 0);
            id_hlt          = ($urandom_range(0, 24) == 0);
            ex_mem_reg      = 1'($urandom_range(0, 1));
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            ex_write_reg    = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        rst_n = 1'b1; idle_in(); tick("final");
        check_perf("perf_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
